// File: rtl/l1_mau_pkg.sv
// Shared types and sizing helpers for the L1 line-fill responder.
package l1_mau_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        ACK  = 2'd2
    } mau_state_t;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_LINE_W = 256;
    localparam int DEF_MEM_DW = 32;

    function automatic int calc_beats(input int line_w, input int mem_dw);
        return line_w / mem_dw;
    endfunction

    function automatic int cnt_width(input int beats);
        return $clog2(beats) + 1;
    endfunction

    localparam int DEF_CNT_W = cnt_width(calc_beats(DEF_LINE_W, DEF_MEM_DW));

endpackage

// File: rtl/l1_mau_line_buf.sv
// Beat-indexed line assembly register; beat 0 lands in the least significant bits.
module l1_mau_line_buf
    import l1_mau_pkg::*;
#(
    parameter int LINE_W = DEF_LINE_W,
    parameter int MEM_DW = DEF_MEM_DW,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [CNT_W-1:0]  wr_idx,
    input  logic [MEM_DW-1:0] wr_data,
    output logic [LINE_W-1:0] line,
    output logic [LINE_W-1:0] line_nxt
);

    localparam int BEATS = calc_beats(LINE_W, MEM_DW);

    logic [LINE_W-1:0] line_q;

    // line_nxt already contains the beat being written, so the final beat can be
    // forwarded to the ack register on the same edge it arrives.
    always_comb begin
        line_nxt = line_q;
        for (int i = 0; i < BEATS; i++) begin
            if (wr_en && (wr_idx == CNT_W'(i))) begin
                line_nxt[i*MEM_DW +: MEM_DW] = wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            line_q <= '0;
        end else if (clr) begin
            line_q <= '0;
        end else begin
            line_q <= line_nxt;
        end
    end

    assign line = line_q;

endmodule

// File: rtl/l1_mau_fill.sv
// L1 line-fill responder: reads a cache line beat by beat from memory and returns it with a 1-cycle ack.
// Optional one-entry last-line buffer enabled by defining MAU_LAST_LINE_EN.
module l1_mau_fill
    import l1_mau_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LINE_W = DEF_LINE_W,
    parameter int MEM_DW = DEF_MEM_DW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mau_req_val,
    input  logic [ADDR_W-1:0] mau_req_addr,
    output logic              mau_req_ack,
    output logic [LINE_W-1:0] mau_ack_data,
    input  logic              mau_flush,
    output logic              mem_req_val,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_req_rdy,
    input  logic              mem_rsp_val,
    input  logic [MEM_DW-1:0] mem_rsp_data
);

    localparam int BEATS = calc_beats(LINE_W, MEM_DW);
    localparam int CNT_W = cnt_width(BEATS);
    localparam logic [ADDR_W-1:0] OFF_MASK   = ADDR_W'(LINE_W/8 - 1);
    localparam logic [ADDR_W-1:0] BEAT_BYTES = ADDR_W'(MEM_DW/8);

    mau_state_t        state_q, state_d;
    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  issue_cnt_q;
    logic [CNT_W-1:0]  rsp_cnt_q;
    logic [LINE_W-1:0] ack_data_q;
    logic [LINE_W-1:0] line_cur, line_nxt;
    logic [ADDR_W-1:0] req_base;
    logic              accept, ll_hit, rsp_wr, beat_acc;

    assign req_base = mau_req_addr & ~OFF_MASK;

`ifdef MAU_LAST_LINE_EN
    logic              ll_valid_q;
    logic [ADDR_W-1:0] ll_addr_q;
    logic [LINE_W-1:0] ll_line_q;
    // A flush in the request cycle wins over a match.
    assign ll_hit = ll_valid_q && (ll_addr_q == req_base) && !mau_flush;
`else
    logic unused_flush;
    assign unused_flush = mau_flush;
    assign ll_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (mau_req_val) begin
                    accept  = 1'b1;
                    state_d = ll_hit ? ACK : FILL;
                end
            end
            FILL: begin
                if (mem_rsp_val && (rsp_cnt_q == CNT_W'(BEATS-1))) state_d = ACK;
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Memory request handshake: a beat transfers on each cycle with mem_req_val & mem_req_rdy;
    // while rdy is low, val and addr stay stable until the beat is taken.
    assign mem_req_val  = (state_q == FILL) && (issue_cnt_q < CNT_W'(BEATS));
    assign mem_req_addr = mem_req_val ? (base_q + ADDR_W'(issue_cnt_q) * BEAT_BYTES) : '0;
    assign beat_acc     = mem_req_val && mem_req_rdy;
    assign rsp_wr       = (state_q == FILL) && mem_rsp_val;
    assign mau_req_ack  = (state_q == ACK);
    assign mau_ack_data = ack_data_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            base_q      <= '0;
            issue_cnt_q <= '0;
            rsp_cnt_q   <= '0;
            ack_data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                base_q      <= req_base;
                issue_cnt_q <= '0;
                rsp_cnt_q   <= '0;
            end else begin
                if (beat_acc) issue_cnt_q <= issue_cnt_q + 1'b1;
                if (rsp_wr)   rsp_cnt_q   <= rsp_cnt_q + 1'b1;
            end
            if ((state_q == FILL) && (state_d == ACK)) ack_data_q <= line_nxt;
`ifdef MAU_LAST_LINE_EN
            if (accept && ll_hit) ack_data_q <= ll_line_q;
`endif
        end
    end

`ifdef MAU_LAST_LINE_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ll_valid_q <= 1'b0;
            ll_addr_q  <= '0;
            ll_line_q  <= '0;
        end else if (mau_flush) begin
            ll_valid_q <= 1'b0;
        end else if (state_q == ACK) begin
            ll_valid_q <= 1'b1;
            ll_addr_q  <= base_q;
            ll_line_q  <= ack_data_q;
        end
    end
`endif

    l1_mau_line_buf #(
        .LINE_W (LINE_W),
        .MEM_DW (MEM_DW),
        .CNT_W  (CNT_W)
    ) u_line_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (accept),
        .wr_en    (rsp_wr),
        .wr_idx   (rsp_cnt_q),
        .wr_data  (mem_rsp_data),
        .line     (line_cur),
        .line_nxt (line_nxt)
    );

    // Responses outside FILL are dropped; flag them as a memory-side protocol error.
    a_rsp_in_fill: assert property (@(posedge clk) disable iff (!rst_n)
        mem_rsp_val |-> (state_q == FILL));

    logic [LINE_W-1:0] unused_line;
    assign unused_line = line_cur;

endmodule
